// File: rtl/mux_pkg.sv
// Shared constants and types for the project-select controller.
// The constants cover the wrapper bundle widths, field offsets and FSM states.
package mux_pkg;

    localparam int unsigned IW_W = 18;
    localparam int unsigned OW_W = 24;

    // Low bit of each field inside the wrapper bundles.
    localparam int unsigned IW_CLK  = 0;
    localparam int unsigned IW_RSTN = 1;
    localparam int unsigned IW_UI   = 2;
    localparam int unsigned IW_UIO  = 10;
    localparam int unsigned OW_UO   = 0;
    localparam int unsigned OW_UIO  = 8;
    localparam int unsigned OW_OE   = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StActive
    } state_e;

endpackage

// File: rtl/mux_ctrl_if.sv
// Bus between the select controller and the bank of project wrappers.
// It carries the flattened per-project input bundles, enables and output bundles.
interface mux_ctrl_if
    import mux_pkg::*;
#(
    parameter int unsigned NUM_PROJ = 24
);

    logic [IW_W*NUM_PROJ-1:0] proj_iw;
    logic [NUM_PROJ-1:0]      proj_ena;
    logic [OW_W*NUM_PROJ-1:0] proj_ow;

    modport master (
        output proj_iw,
        output proj_ena,
        input  proj_ow
    );

    modport slave (
        input  proj_iw,
        input  proj_ena,
        output proj_ow
    );

endinterface

// File: rtl/mux_sync2.sv
// Two-flop synchroniser for asynchronous pad strobes.
// Both flops reset to 0.
module mux_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/mux_ctrl.sv
// Project-select controller: tracks the selected project from pad strobes and enables
// exactly one wrapper, with a settle gap between every address change and the new enable.
module mux_ctrl
    import mux_pkg::*;
#(
    parameter int unsigned NUM_PROJ   = 24,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_sel_rst_n,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    input  logic [IW_W-1:0]   pad_iw,
    mux_ctrl_if.master        proj,
    output logic [OW_W-1:0]   pad_ow,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_active
);

    localparam logic [3:0]      SettleLoad = 4'(SETTLE_CYC - 1);
    localparam logic [ADDR_W:0] NumProjCmp = (ADDR_W + 1)'(NUM_PROJ);

    logic                sel_rst_s, inc_s, ena_s, inc_q;
    logic                inc_edge, addr_chg, addr_ok;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NUM_PROJ-1:0] ena_q, ena_d;
    logic                active_q;

    mux_sync2 u_sync_sel_rst (.clk(clk), .rst_n(rst_n), .d(ctrl_sel_rst_n), .q(sel_rst_s));
    mux_sync2 u_sync_inc     (.clk(clk), .rst_n(rst_n), .d(ctrl_sel_inc),   .q(inc_s));
    mux_sync2 u_sync_ena     (.clk(clk), .rst_n(rst_n), .d(ctrl_ena),       .q(ena_s));

    assign inc_edge = inc_s & ~inc_q;
    assign addr_ok  = ({1'b0, addr_q} < NumProjCmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q    <= 1'b0;
            addr_q   <= '0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            ena_q    <= '0;
            active_q <= 1'b0;
        end else begin
            inc_q    <= inc_s;
            addr_q   <= addr_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ena_q    <= ena_d;
            active_q <= (state_d == StActive);
        end
    end

    // Select-reset dominates; clearing an already-zero address is not a change.
    always_comb begin
        addr_d   = addr_q;
        addr_chg = 1'b0;
        if (!sel_rst_s) begin
            addr_d   = '0;
            addr_chg = (addr_q != '0);
        end else if (inc_edge) begin
            addr_d   = addr_q + 1'b1;
            addr_chg = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (addr_chg || !ena_s) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (addr_ok) begin
                        state_d = StSettle;
                        cnt_d   = SettleLoad;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_d = StActive;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StActive: state_d = StActive;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Enables are decoded from the next state so they register together with it.
    always_comb begin
        ena_d = '0;
        for (int unsigned i = 0; i < NUM_PROJ; i++) begin
            ena_d[i] = (state_d == StActive) && (addr_d == ADDR_W'(i));
        end
    end

    always_comb begin
        proj.proj_iw = '0;
        pad_ow       = '0;
        for (int unsigned i = 0; i < NUM_PROJ; i++) begin
            if (ena_q[i]) begin
                proj.proj_iw[IW_W*i +: IW_W] = pad_iw;
            end
            if (active_q && (addr_q == ADDR_W'(i))) begin
                pad_ow = proj.proj_ow[OW_W*i +: OW_W];
            end
        end
    end

    assign proj.proj_ena = ena_q;
    assign sel_addr      = addr_q;
    assign sel_active    = active_q;

endmodule

// File: tb/tb_mux_ctrl.sv
// Self-checking bench for mux_ctrl: directed pad-strobe sequences, a per-cycle
// behavioural model compare, and literal expectations at the key points.
module tb_mux_ctrl;
    import mux_pkg::*;

    localparam int unsigned NUM_PROJ   = 24;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned SETTLE_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
    logic [IW_W-1:0]   pad_iw;
    logic [OW_W-1:0]   pad_ow;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_active;

    mux_ctrl_if #(.NUM_PROJ(NUM_PROJ)) proj_bus ();

    mux_ctrl #(
        .NUM_PROJ  (NUM_PROJ),
        .ADDR_W    (ADDR_W),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl_sel_rst_n(ctrl_sel_rst_n),
        .ctrl_sel_inc  (ctrl_sel_inc),
        .ctrl_ena      (ctrl_ena),
        .pad_iw        (pad_iw),
        .proj          (proj_bus),
        .pad_ow        (pad_ow),
        .sel_addr      (sel_addr),
        .sel_active    (sel_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: pad history stands in for the synchroniser delay; a project is enabled once
    // SETTLE_CYC+1 consecutive edges have seen ena high, an in-range address and no change.
    int unsigned m_addr, m_nxt;
    int          m_run;
    bit          m_on, m_chg, m_edge, m_srst, m_sena;
    bit          rst1, rst2, inc1, inc2, inc3, ena1, ena2;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                {rst1, rst2, inc1, inc2, inc3, ena1, ena2} = '0;
                m_addr = 0;
                m_run  = 0;
                m_on   = 1'b0;
            end else begin
                m_srst = rst2;
                m_sena = ena2;
                m_edge = inc2 && !inc3;
                inc3 = inc2; inc2 = inc1; inc1 = ctrl_sel_inc;
                rst2 = rst1; rst1 = ctrl_sel_rst_n;
                ena2 = ena1; ena1 = ctrl_ena;
                if (!m_srst) begin
                    m_chg = (m_addr != 0);
                    m_nxt = 0;
                end else begin
                    m_chg = m_edge;
                    m_nxt = (m_addr + (m_edge ? 1 : 0)) % (1 << ADDR_W);
                end
                if (m_chg || !m_sena || m_nxt >= NUM_PROJ) m_run = 0;
                else if (m_run < 1000) m_run++;
                m_addr = m_nxt;
                m_on   = (m_run >= SETTLE_CYC + 1);
            end
        end
    end

    logic [NUM_PROJ-1:0]      exp_ena;
    logic [IW_W*NUM_PROJ-1:0] exp_iw;
    logic [OW_W-1:0]          exp_ow;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            exp_ena = '0;
            exp_iw  = '0;
            exp_ow  = '0;
            if (m_on) begin
                exp_ena[m_addr]          = 1'b1;
                exp_iw[m_addr*IW_W +: IW_W] = pad_iw;
                exp_ow                   = proj_bus.proj_ow[m_addr*OW_W +: OW_W];
            end
            check("cyc_addr", sel_addr, m_addr);
            check("cyc_ena", proj_bus.proj_ena, exp_ena);
            check("cyc_active", sel_active, m_on);
            check("cyc_pad_ow", pad_ow, exp_ow);
            check("cyc_proj_iw", proj_bus.proj_iw, exp_iw);
            check("cyc_onehot", ($countones(proj_bus.proj_ena) <= 1), 1);
        end
    end

    // Raise the pad increment; return 2 ns after the edge where the increment lands.
    task automatic inc_land();
        ctrl_sel_inc = 1'b0;
        repeat (2) @(negedge clk);
        ctrl_sel_inc = 1'b1;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [IW_W*NUM_PROJ-1:0] iw_mask;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        ctrl_sel_rst_n = 1'b1;
        ctrl_sel_inc   = 1'b0;
        ctrl_ena       = 1'b1;
        pad_iw         = 18'h2ABCD;
        for (int i = 0; i < NUM_PROJ; i++) begin
            proj_bus.proj_ow[i*OW_W +: OW_W] = 24'hA5C3F0 ^ (24'(i) * 24'h010101);
        end
        repeat (3) @(negedge clk);
        check("rst_ena", proj_bus.proj_ena, 0);
        check("rst_iw", proj_bus.proj_iw, 0);
        check("rst_ow", pad_ow, 0);
        check("rst_addr", sel_addr, 0);
        rst_n = 1'b1;

        // Enable from reset: 2 sync + 1 + SETTLE_CYC edges.
        edges(6);
        check("settle_ena", proj_bus.proj_ena, 0);
        check("settle_ow", pad_ow, 0);
        check("settle_iw0", proj_bus.proj_iw[17:0], 0);
        edges(1);
        check("first_ena", proj_bus.proj_ena, 24'h000001);
        check("first_ow", pad_ow, 24'hA5C3F0);
        check("first_iw0", proj_bus.proj_iw[17:0], 18'h2ABCD);

        // Three increments while active.
        inc_land();
        check("inc1_drop", proj_bus.proj_ena, 0);
        check("inc1_addr", sel_addr, 1);
        inc_land();
        inc_land();
        check("inc3_addr", sel_addr, 3);
        edges(4);
        check("inc3_wait", proj_bus.proj_ena, 0);
        edges(1);
        check("inc3_ena", proj_bus.proj_ena, 24'h000008);
        check("inc3_iw3", proj_bus.proj_iw[3*IW_W +: IW_W], 18'h2ABCD);
        iw_mask = '0;
        iw_mask[3*IW_W +: IW_W] = '1;
        check("inc3_iw_others", proj_bus.proj_iw & ~iw_mask, 0);

        // Out-of-range address, then wrap back to 0.
        repeat (21) inc_land();
        check("oor_addr", sel_addr, 24);
        edges(10);
        check("oor_ena", proj_bus.proj_ena, 0);
        check("oor_ow", pad_ow, 0);
        check("oor_active", sel_active, 0);
        repeat (8) inc_land();
        check("wrap_addr", sel_addr, 0);
        edges(5);
        check("wrap_ena", proj_bus.proj_ena, 24'h000001);

        // Select-reset beats a simultaneous increment at address 5.
        repeat (5) inc_land();
        edges(6);
        check("a5_ena", proj_bus.proj_ena, 24'h000020);
        ctrl_sel_inc = 1'b0;
        repeat (2) @(negedge clk);
        ctrl_sel_inc   = 1'b1;
        ctrl_sel_rst_n = 1'b0;
        edges(3);
        check("srst_addr", sel_addr, 0);
        check("srst_ena", proj_bus.proj_ena, 0);
        check("srst_active", sel_active, 0);
        @(negedge clk);
        ctrl_sel_rst_n = 1'b1;
        ctrl_sel_inc   = 1'b0;
        edges(8);
        check("srst_reena", proj_bus.proj_ena, 24'h000001);

        // ctrl_ena drop and re-raise at address 7.
        repeat (7) inc_land();
        edges(6);
        check("a7_ena", proj_bus.proj_ena, 24'h000080);
        @(negedge clk);
        ctrl_ena = 1'b0;
        edges(2);
        check("drop_hold", proj_bus.proj_ena, 24'h000080);
        edges(1);
        check("drop_ena", proj_bus.proj_ena, 0);
        check("drop_ow", pad_ow, 0);
        check("drop_addr", sel_addr, 7);
        @(negedge clk);
        ctrl_ena = 1'b1;
        edges(6);
        check("raise_wait", proj_bus.proj_ena, 0);
        edges(1);
        check("raise_ena", proj_bus.proj_ena, 24'h000080);
        check("raise_ow", pad_ow, 24'hA2C4F7);

        // Asynchronous reset in the middle of a settle.
        @(negedge clk);
        ctrl_ena = 1'b0;
        edges(4);
        @(negedge clk);
        ctrl_ena = 1'b1;
        edges(5);
        check("mid_settle_addr", sel_addr, 7);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_addr", sel_addr, 0);
        check("arst_ena", proj_bus.proj_ena, 0);
        check("arst_active", sel_active, 0);
        check("arst_ow", pad_ow, 0);
        check("arst_iw", proj_bus.proj_iw, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        edges(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
